alu_result_display: RTL and testbench

ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

---
 rtl/alu_result_display_pkg.sv | 43 ++++
 rtl/alu_result_display_seg7_decode.sv | 17 +
 rtl/alu_result_display.sv | 136 +++++++++++++
 tb/tb_alu_result_display.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_display_pkg.sv
// Shared types and constants for the ALU result display: conversion FSM states,
// seven-segment encodings and the double-dabble iteration step.
package alu_result_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 3;
    localparam int CONV_ITERS = 8;
    localparam int BIN_W      = 8;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int SHIFT_W    = BIN_W + BCD_W;
    localparam int ITER_W     = $clog2(CONV_ITERS);

    // Segment patterns ordered {g,f,e,d,c,b,a}, indexed by decimal digit
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0111111,
        7'b0000110,
        7'b1011011,
        7'b1001111,
        7'b1100110,
        7'b1101101,
        7'b1111101,
        7'b0000111,
        7'b1111111,
        7'b1101111
    };

    // One double-dabble iteration over {bcd digits, binary}: correct then shift
    function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] sr);
        logic [SHIFT_W-1:0] adj;
        adj = sr;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (adj[BIN_W + 4*d +: 4] >= 4'd5) begin
                adj[BIN_W + 4*d +: 4] = adj[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        return {adj[SHIFT_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/alu_result_display_seg7_decode.sv
// Combinational BCD nibble to seven-segment decoder; non-decimal nibbles
// produce a dark digit.
module seg7_decode
    import alu_result_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0000000;
        if (nibble <= 4'd9) begin
            seg = SEG_TABLE[nibble];
        end
    end

endmodule

// File: rtl/alu_result_display.sv
// Converts an 8-bit ALU result to three BCD digits with a sequential
// double-dabble engine and scans them onto a multiplexed seven-segment display.
module alu_result_display
    import alu_result_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  result,
    input  logic        load,
    output logic        busy,
    output logic        valid,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  dig_sel
);

    localparam int               PRE_W     = 20;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(CONV_ITERS - 1);
    localparam logic [1:0]       LAST_DIG  = 2'(NUM_DIGITS - 1);

    state_t               state;
    state_t               state_next;
    logic [SHIFT_W-1:0]   shreg;
    logic [SHIFT_W-1:0]   shreg_next;
    logic [ITER_W-1:0]    iter;
    logic [ITER_W-1:0]    iter_next;
    logic [BCD_W-1:0]     bcd_next;
    logic                 valid_next;

    logic [PRE_W-1:0]     pre_cnt;
    logic                 wrap;
    logic [1:0]           dig_idx;
    logic [1:0]           dig_idx_next;
    logic [2:0]           sel_next;
    logic [3:0]           nibble;
    logic                 blank;
    logic [6:0]           seg_raw;

    assign busy = (state == CONV);

    // Load is only honoured from IDLE, so strobes during a conversion are dropped
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        iter_next  = iter;
        bcd_next   = bcd;
        valid_next = valid;
        case (state)
            IDLE: begin
                if (load) begin
                    shreg_next = {{BCD_W{1'b0}}, result};
                    iter_next  = '0;
                    state_next = CONV;
                end
            end
            CONV: begin
                shreg_next = dabble_step(shreg);
                iter_next  = iter + 1'b1;
                if (iter == LAST_ITER) begin
                    bcd_next   = shreg_next[SHIFT_W-1 -: BCD_W];
                    valid_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            iter  <= '0;
            bcd   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            iter  <= iter_next;
            bcd   <= bcd_next;
            valid <= valid_next;
        end
    end

    assign wrap = (pre_cnt == PRE_LAST);

    always_comb begin
        dig_idx_next = dig_idx;
        if (wrap) begin
            dig_idx_next = (dig_idx == LAST_DIG) ? 2'd0 : dig_idx + 2'd1;
        end
    end

    // Decode for the digit that becomes active on this edge so seg and dig_sel move together
    always_comb begin
        nibble   = bcd[3:0];
        blank    = 1'b0;
        sel_next = 3'b001;
        case (dig_idx_next)
            2'd1: begin
                nibble   = bcd[7:4];
                blank    = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
                sel_next = 3'b010;
            end
            2'd2: begin
                nibble   = bcd[11:8];
                blank    = (bcd[11:8] == 4'd0);
                sel_next = 3'b100;
            end
            default: ;
        endcase
    end

    seg7_decode u_seg7_decode (
        .nibble (nibble),
        .seg    (seg_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            dig_idx <= 2'd0;
            dig_sel <= 3'b001;
            seg     <= 7'b0000000;
        end else begin
            pre_cnt <= wrap ? '0 : pre_cnt + 1'b1;
            dig_idx <= dig_idx_next;
            dig_sel <= sel_next;
            seg     <= (valid && !blank) ? seg_raw : 7'b0000000;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Randomised scoreboard bench for alu_result_display against a decimal-arithmetic
// reference model of conversion timing and display scanning.
module tb_alu_result_display;

    localparam int SCAN_DIV = 4;

    localparam logic [6:0] SEG_REF [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    typedef struct {
        logic [11:0] bcd;
        int          done;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  result;
    logic        load;
    logic        busy;
    logic        valid;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  dig_sel;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    int         cyc     = 0;
    int         m_val   = 0;
    int         m_pend  = 0;
    int         m_done  = 0;
    bit         m_valid = 1'b0;
    bit         m_busy  = 1'b0;
    int         m_digit = 0;
    logic [6:0] m_seg   = 7'b0000000;

    alu_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .result  (result),
        .load    (load),
        .busy    (busy),
        .valid   (valid),
        .bcd     (bcd),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input bit vld, input int digit);
        int h;
        int t;
        int o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        if (!vld) return 7'b0000000;
        case (digit)
            0:       return SEG_REF[o];
            1:       return (h == 0 && t == 0) ? 7'b0000000 : SEG_REF[t];
            default: return (h == 0) ? 7'b0000000 : SEG_REF[h];
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] val, input int hold);
        result = val;
        load   = 1'b1;
        waitCycles(hold);
        load   = 1'b0;
    endtask

    // Reference model: a load seen while idle completes exactly 8 edges later
    initial begin
        int  old_val;
        bit  old_valid;
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                cyc     = 0;
                m_val   = 0;
                m_valid = 1'b0;
                m_busy  = 1'b0;
                m_digit = 0;
                m_seg   = 7'b0000000;
                sb_q.delete();
            end else begin
                old_val   = m_val;
                old_valid = m_valid;
                cyc++;
                if (m_busy) begin
                    if (cyc == m_done) begin
                        m_val   = m_pend;
                        m_valid = 1'b1;
                        m_busy  = 1'b0;
                    end
                end else if (load) begin
                    m_busy = 1'b1;
                    m_done = cyc + 8;
                    m_pend = int'(result);
                    e.bcd  = to_bcd(int'(result));
                    e.done = cyc + 8;
                    sb_q.push_back(e);
                end
                m_digit = (cyc / SCAN_DIV) % 3;
                m_seg   = exp_seg(old_val, old_valid, m_digit);
            end
        end
    end

    // Monitor: a falling busy marks a finished conversion, matched against the scoreboard
    initial begin
        bit   prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    checkOutput("sb_nonempty", 32'(sb_q.size() > 0), 32'(1));
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        checkOutput("sb_bcd", 32'(bcd), 32'(e.bcd));
                        checkOutput("sb_latency", 32'(cyc), 32'(e.done));
                        checkOutput("sb_valid", 32'(valid), 32'(1));
                    end
                end
                prev_busy = busy;
            end
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("valid", 32'(valid), 32'(m_valid));
            checkOutput("bcd", 32'(bcd), 32'(to_bcd(m_val)));
            checkOutput("dig_sel", 32'(dig_sel), 32'(1) << m_digit);
            checkOutput("seg", 32'(seg), 32'(m_seg));
        end
    end

    initial begin
        int v;
        int hold;
        rst    = 1'b0;
        load   = 1'b0;
        result = 8'd0;
        #3 rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        waitCycles(3);

        applyStimulus(8'd255, 1);
        waitCycles(12);
        applyStimulus(8'd0, 1);
        waitCycles(20);
        applyStimulus(8'd100, 1);
        waitCycles(2);
        applyStimulus(8'd7, 1);
        waitCycles(12);
        applyStimulus(8'd99, 1);
        waitCycles(20);

        applyStimulus(8'd200, 1);
        waitCycles(3);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        waitCycles(2);
        applyStimulus(8'd9, 1);
        waitCycles(12);

        applyStimulus(8'd128, 1);
        waitCycles(7);
        applyStimulus(8'd64, 1);
        waitCycles(14);

        repeat (40) begin
            v    = int'($urandom_range(0, 255));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : 1;
            applyStimulus(8'(v), hold);
            waitCycles(int'($urandom_range(0, 12)));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                waitCycles(1);
                rst = 1'b0;
            end
        end

        waitCycles(14);
        checkOutput("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
